channel_scan_ctrl: RTL

Parametrised channel-selection controller between the MEGAWING DIP switches, the board LEDs and the ADC SPI master. It synchronises and debounces the switch inputs, and it offers two modes: a manual single-channel mode and an automatic scan mode that steps through a switch-defined channel mask. It applies address changes only on conversion boundaries, and it reports invalid switch settings instead of silently defaulting to channel 0.

---
 rtl/channel_scan_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/channel_scan_ctrl.sv
// Channel selection between DIP switches, LEDs and the ADC SPI master.
// Switches are synchronised and debounced; manual or mask-scan modes update the address only at conversion boundaries.
module channel_scan_ctrl #(
  parameter int          N_CH            = 8,
  parameter int          ADDR_W          = $clog2(N_CH),
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          SCAN_DWELL      = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_CH-1:0]   sw,
  input  logic              scan_en,
  input  logic              conv_done,
  input  logic              spi_idle,
  output logic [ADDR_W-1:0] ch_addr,
  output logic              ch_valid,
  output logic              ch_changed,
  output logic [N_CH-1:0]   led,
  output logic              sw_error
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_MANUAL = 2'd1;
  localparam logic [1:0]  ST_SCAN   = 2'd2;
  localparam logic [15:0] DB_LAST   = DEBOUNCE_CYCLES - 16'd1;
  localparam int          DW_W      = $clog2(SCAN_DWELL + 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DWELL - 1);

  function automatic logic is_onehot(input logic [N_CH-1:0] v);
    return (v != '0) && ((v & (v - N_CH'(1'b1))) == '0);
  endfunction

  function automatic logic [ADDR_W-1:0] lowest_idx(input logic [N_CH-1:0] v);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = ADDR_W'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  // First set mask bit strictly above cur, wrapping; returns cur when it is the only set bit.
  function automatic logic [ADDR_W-1:0] next_bit(input logic [N_CH-1:0] mask,
                                                 input logic [ADDR_W-1:0] cur);
    logic [ADDR_W-1:0] nxt;
    logic              found;
    int                j;
    nxt   = cur;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      j = (int'(cur) + k) % N_CH;
      if (!found && mask[j]) begin
        nxt   = ADDR_W'(j);
        found = 1'b1;
      end else begin
        nxt   = nxt;
      end
    end
    return nxt;
  endfunction

  logic [N_CH:0]       sync1_r, sync2_r, prev_r, stable_r;
  logic [15:0]         db_cnt_r;
  logic [1:0]          state_r, state_nxt_s;
  logic [DW_W-1:0]     dwell_r, dwell_nxt_s;
  logic [ADDR_W-1:0]   addr_nxt_s, man_addr_s, adv_addr_s, enter_addr_s;
  logic                valid_nxt_s, apply_s, man_ok_s, mask_ok_s, in_mask_s, scan_stable_s;
  logic [N_CH-1:0]     sw_stable_s;

  // Target selection and the mode FSM, evaluated only on apply cycles.
  always_comb begin
    sw_stable_s   = stable_r[N_CH-1:0];
    scan_stable_s = stable_r[N_CH];
    apply_s       = conv_done | spi_idle | (state_r == ST_IDLE);
    man_ok_s      = is_onehot(sw_stable_s);
    man_addr_s    = lowest_idx(sw_stable_s);
    mask_ok_s     = |sw_stable_s;
    in_mask_s     = sw_stable_s[ch_addr];
    adv_addr_s    = next_bit(sw_stable_s, ch_addr);
    enter_addr_s  = in_mask_s ? ch_addr : adv_addr_s;
    state_nxt_s   = state_r;
    addr_nxt_s    = ch_addr;
    valid_nxt_s   = ch_valid;
    dwell_nxt_s   = dwell_r;
    if (apply_s) begin
      case (state_r)
        ST_IDLE: begin
          if (scan_stable_s && mask_ok_s) begin
            state_nxt_s = ST_SCAN;
            valid_nxt_s = 1'b1;
            addr_nxt_s  = enter_addr_s;
            dwell_nxt_s = '0;
          end else if (!scan_stable_s && man_ok_s) begin
            state_nxt_s = ST_MANUAL;
            valid_nxt_s = 1'b1;
            addr_nxt_s  = man_addr_s;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_MANUAL: begin
          if (scan_stable_s && mask_ok_s) begin
            state_nxt_s = ST_SCAN;
            addr_nxt_s  = enter_addr_s;
            dwell_nxt_s = '0;
          end else if (scan_stable_s) begin
            state_nxt_s = ST_IDLE;
            valid_nxt_s = 1'b0;
          end else if (man_ok_s) begin
            addr_nxt_s  = man_addr_s;
          end else begin
            addr_nxt_s  = ch_addr;
          end
        end
        ST_SCAN: begin
          if (!scan_stable_s) begin
            state_nxt_s = ST_MANUAL;
            addr_nxt_s  = man_ok_s ? man_addr_s : ch_addr;
          end else if (!mask_ok_s) begin
            state_nxt_s = ST_IDLE;
            valid_nxt_s = 1'b0;
          end else if (!in_mask_s) begin
            addr_nxt_s  = adv_addr_s;
            dwell_nxt_s = '0;
          end else if (conv_done && dwell_r == DWELL_LAST) begin
            addr_nxt_s  = adv_addr_s;
            dwell_nxt_s = '0;
          end else if (conv_done) begin
            dwell_nxt_s = dwell_r + DW_W'(1'b1);
          end else begin
            dwell_nxt_s = dwell_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          valid_nxt_s = 1'b0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Input conditioning, state and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_r    <= '0;
      sync2_r    <= '0;
      prev_r     <= '0;
      stable_r   <= '0;
      db_cnt_r   <= 16'd0;
      state_r    <= ST_IDLE;
      dwell_r    <= '0;
      ch_addr    <= '0;
      ch_valid   <= 1'b0;
      ch_changed <= 1'b0;
      led        <= '0;
      sw_error   <= 1'b0;
    end else begin
      sync1_r <= {scan_en, sw};
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      if (sync2_r != prev_r)      db_cnt_r <= 16'd0;
      else if (db_cnt_r != DB_LAST) db_cnt_r <= db_cnt_r + 16'd1;
      else                        db_cnt_r <= db_cnt_r;
      if (db_cnt_r == DB_LAST && prev_r != stable_r) stable_r <= prev_r;
      else                                           stable_r <= stable_r;
      state_r    <= state_nxt_s;
      dwell_r    <= dwell_nxt_s;
      ch_addr    <= addr_nxt_s;
      ch_valid   <= valid_nxt_s;
      ch_changed <= (addr_nxt_s != ch_addr);
      led        <= valid_nxt_s ? (N_CH'(1'b1) << addr_nxt_s) : '0;
      sw_error   <= !scan_stable_s && !man_ok_s;
    end
  end

endmodule
